qam_rx_sequencer: RTL and testbench

Frame-level controller for the QAM-16 receive chain: cut_pilot, carrier multiply, raised-cosine filter, sampling, then PLL.
- Soft-resets (flushes) the chain, then issues start.
- Tracks each stage's ready rising in pipeline order under a per-stage watchdog.
- Counts PLL output symbols until the frame is complete and reports done or error upstream.
- Sits beside the receiver top level, on the same system clock as gen_clk's input.

---
 rtl/qam_rx_pkg.sv | 45 ++++
 rtl/qam_rx_watchdog.sv | 32 +++
 rtl/qam_rx_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_qam_rx_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_rx_pkg.sv
// qam_rx_pkg: state encoding, error codes and default timing shared by
// qam_rx_sequencer and qam_rx_watchdog.
package qam_rx_pkg;

  typedef logic [3:0] state_t;

  // Wait states are contiguous so the awaited stage index is state - ST_W_CUT.
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FLUSH   = 4'd1;
  localparam logic [3:0] ST_START   = 4'd2;
  localparam logic [3:0] ST_W_CUT   = 4'd3;
  localparam logic [3:0] ST_W_CARRY = 4'd4;
  localparam logic [3:0] ST_W_FIL   = 4'd5;
  localparam logic [3:0] ST_W_SAMP  = 4'd6;
  localparam logic [3:0] ST_W_PLL   = 4'd7;
  localparam logic [3:0] ST_RUN     = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;
  localparam logic [3:0] ST_ERR     = 4'd10;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CUT   = 3'd1;
  localparam logic [2:0] ERR_CARRY = 3'd2;
  localparam logic [2:0] ERR_FIL   = 3'd3;
  localparam logic [2:0] ERR_SAMP  = 3'd4;
  localparam logic [2:0] ERR_PLL   = 3'd5;
  localparam logic [2:0] ERR_GAP   = 3'd6;
  localparam logic [2:0] ERR_ABORT = 3'd7;

  localparam int         DEF_TIMEOUT_W     = 16;
  localparam int         DEF_STAGE_TIMEOUT = 4000;
  localparam int         DEF_SYM_TIMEOUT   = 2000;
  localparam logic [7:0] DEF_FLUSH_CYC     = 8'd16;
  localparam int         DEF_SYM_W         = 12;
  localparam int         DEF_SYM_PER_FRAME = 256;

  function automatic logic is_busy(input state_t s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
  endfunction

  // Timeout code for wait stage idx (0 = cut_pilot .. 4 = PLL lock).
  function automatic logic [2:0] stage_code(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/qam_rx_watchdog.sv
// qam_rx_watchdog: saturating cycle counter; expired is high during the
// limit-th cycle since the last clear, and the count never wraps.
module qam_rx_watchdog
  import qam_rx_pkg::*;
#(
  parameter int W = DEF_TIMEOUT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign expired = (cnt_inc >= {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt_inc[W-1:0];
    end
  end

endmodule

// File: rtl/qam_rx_sequencer.sv
// qam_rx_sequencer: frame controller for the QAM-16 receive chain (flush, start,
// per-stage ready watchdog, symbol counting). Optional stats via QAM_RX_SEQ_STATS_EN.
module qam_rx_sequencer
  import qam_rx_pkg::*;
#(
  parameter int                   TIMEOUT_W     = DEF_TIMEOUT_W,
  parameter logic [TIMEOUT_W-1:0] STAGE_TIMEOUT = TIMEOUT_W'(DEF_STAGE_TIMEOUT),
  parameter logic [TIMEOUT_W-1:0] SYM_TIMEOUT   = TIMEOUT_W'(DEF_SYM_TIMEOUT),
  parameter logic [7:0]           FLUSH_CYC     = DEF_FLUSH_CYC,
  parameter int                   SYM_W         = DEF_SYM_W,
  parameter logic [SYM_W-1:0]     SYM_PER_FRAME = SYM_W'(DEF_SYM_PER_FRAME)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_req,
  input  logic             abort,
  input  logic             ready_cut,
  input  logic             ready_carry,
  input  logic             ready_fil,
  input  logic             ready_sampling,
  input  logic             ready_pll,
  output logic             chain_rst_n,
  output logic             start,
  output logic             busy,
  output logic [SYM_W-1:0] sym_cnt,
  output logic             done,
  output logic             err,
`ifdef QAM_RX_SEQ_STATS_EN
  output logic [15:0]      frame_ok_cnt,
  output logic [15:0]      frame_err_cnt,
`endif
  output logic [2:0]       err_code
);

  state_t               state;
  state_t               state_next;
  logic [2:0]           code_next;
  logic                 err_next;
  logic [SYM_W-1:0]     sym_next;
  logic [SYM_W-1:0]     sym_inc;
  logic [2:0]           stage_idx;
  logic                 wd_clear;
  logic                 wd_enable;
  logic                 wd_expired;
  logic [TIMEOUT_W-1:0] wd_limit;
  logic [4:0]           ready_q;
  logic [4:0]           ready_d;
  logic [4:0]           ready_rise;

  // Readies are registered once; a rise is registered 1 after registered 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= '0;
      ready_d <= '0;
    end else begin
      ready_q <= {ready_pll, ready_sampling, ready_fil, ready_carry, ready_cut};
      ready_d <= ready_q;
    end
  end

  assign ready_rise = ready_q & ~ready_d;
  assign stage_idx  = 3'(state - ST_W_CUT);
  assign sym_inc    = sym_cnt + SYM_W'(1);
  assign wd_enable  = (state != ST_IDLE) && (state != ST_DONE);

  // One watchdog serves flush length, stage timeouts and the symbol gap.
  always_comb begin
    case (state)
      ST_FLUSH, ST_ERR: wd_limit = TIMEOUT_W'(FLUSH_CYC);
      ST_RUN:           wd_limit = SYM_TIMEOUT;
      default:          wd_limit = STAGE_TIMEOUT;
    endcase
  end

  qam_rx_watchdog #(.W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (wd_limit),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state;
    code_next  = err_code;
    err_next   = err;
    sym_next   = sym_cnt;
    wd_clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_req) begin
          state_next = ST_FLUSH;
          code_next  = ERR_NONE;
          err_next   = 1'b0;
          sym_next   = '0;
        end
      end
      ST_FLUSH: begin
        if (wd_expired) state_next = ST_START;
      end
      ST_START: state_next = ST_W_CUT;
      ST_W_CUT, ST_W_CARRY, ST_W_FIL, ST_W_SAMP: begin
        // A rise on the last permitted cycle beats the timeout.
        if (ready_rise[stage_idx]) begin
          state_next = state + 4'd1;
        end else if (wd_expired) begin
          state_next = ST_ERR;
          code_next  = stage_code(stage_idx);
        end
      end
      ST_W_PLL: begin
        if (ready_rise[4]) begin
          sym_next   = SYM_W'(1);
          state_next = (SYM_PER_FRAME <= SYM_W'(1)) ? ST_DONE : ST_RUN;
        end else if (wd_expired) begin
          state_next = ST_ERR;
          code_next  = ERR_PLL;
        end
      end
      ST_RUN: begin
        if (ready_rise[4]) begin
          sym_next = sym_inc;
          wd_clear = 1'b1;
          if (sym_inc >= SYM_PER_FRAME) state_next = ST_DONE;
        end else if (wd_expired) begin
          state_next = ST_ERR;
          code_next  = ERR_GAP;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR: begin
        if (wd_expired) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort overrides any same-cycle rise or timeout in a busy state.
    if (is_busy(state) && abort) begin
      state_next = ST_ERR;
      code_next  = ERR_ABORT;
      sym_next   = sym_cnt;
    end

    if (state_next == ST_ERR && state != ST_ERR) err_next = 1'b1;
    if (state_next != state) wd_clear = 1'b1;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sym_cnt     <= '0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      chain_rst_n <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      sym_cnt     <= sym_next;
      err         <= err_next;
      err_code    <= code_next;
      chain_rst_n <= !(state_next == ST_FLUSH || state_next == ST_ERR);
      start       <= (state_next >= ST_START) && (state_next <= ST_RUN);
      busy        <= is_busy(state_next);
      done        <= (state_next == ST_DONE);
    end
  end

`ifdef QAM_RX_SEQ_STATS_EN
  logic enter_done;
  logic enter_err;

  assign enter_done = (state_next == ST_DONE) && (state != ST_DONE);
  assign enter_err  = (state_next == ST_ERR) && (state != ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok_cnt  <= 16'd0;
      frame_err_cnt <= 16'd0;
    end else begin
      if (enter_done && frame_ok_cnt != 16'hFFFF) frame_ok_cnt <= frame_ok_cnt + 16'd1;
      if (enter_err && frame_err_cnt != 16'hFFFF) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qam_rx_sequencer.sv
// tb_qam_rx_sequencer: randomized frames checked cycle by cycle against a
// timeline model built from stage delays, symbol gaps and abort time.
module tb_qam_rx_sequencer;

  localparam int F   = 4;
  localparam int T   = 50;
  localparam int S   = 30;
  localparam int SPF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_req = 1'b0;
  logic        abort = 1'b0;
  logic        ready_cut = 1'b0;
  logic        ready_carry = 1'b0;
  logic        ready_fil = 1'b0;
  logic        ready_sampling = 1'b0;
  logic        ready_pll = 1'b0;
  logic        chain_rst_n;
  logic        start;
  logic        busy;
  logic [11:0] sym_cnt;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
`ifdef QAM_RX_SEQ_STATS_EN
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int d[5];
  int g[4];
  int abort_at;
  int ok_model = 0;
  int err_model = 0;

  always #5 clk = ~clk;

  qam_rx_sequencer #(
    .TIMEOUT_W     (16),
    .STAGE_TIMEOUT (16'(T)),
    .SYM_TIMEOUT   (16'(S)),
    .FLUSH_CYC     (8'(F)),
    .SYM_W         (12),
    .SYM_PER_FRAME (12'(SPF))
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_req      (frame_req),
    .abort          (abort),
    .ready_cut      (ready_cut),
    .ready_carry    (ready_carry),
    .ready_fil      (ready_fil),
    .ready_sampling (ready_sampling),
    .ready_pll      (ready_pll),
    .chain_rst_n    (chain_rst_n),
    .start          (start),
    .busy           (busy),
    .sym_cnt        (sym_cnt),
    .done           (done),
    .err            (err),
`ifdef QAM_RX_SEQ_STATS_EN
    .frame_ok_cnt   (frame_ok_cnt),
    .frame_err_cnt  (frame_err_cnt),
`endif
    .err_code       (err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    frame_req      = 1'b0;
    abort          = 1'b0;
    ready_cut      = 1'b0;
    ready_carry    = 1'b0;
    ready_fil      = 1'b0;
    ready_sampling = 1'b0;
    ready_pll      = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef QAM_RX_SEQ_STATS_EN
    check({tag, " ok_cnt"}, 32'(frame_ok_cnt), 32'(ok_model));
    check({tag, " err_cnt"}, 32'(frame_err_cnt), 32'(err_model));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Edge 0 is the edge that samples frame_req in IDLE. A ready sampled high
  // at edge p by a waiting state advances the state at edge p+1.
  task automatic run_frame(input int id, input int stop_sym);
    int  p[5];
    bit  pv[5];
    int  pll_q[$];
    int  inc_q[$];
    int  t, end_e, code, last, c, kmax, symx;
    bit  is_err, drive_pll;
    string tg;

    for (int i = 0; i < 5; i++) begin
      p[i]  = 0;
      pv[i] = 1'b0;
    end
    is_err = 1'b0;
    code   = 0;
    end_e  = 0;
    t      = F + 1;
    for (int i = 0; i < 5; i++) begin
      if (d[i] >= T) begin
        is_err = 1'b1;
        code   = i + 1;
        end_e  = t + T;
        break;
      end
      p[i]  = t + d[i];
      pv[i] = 1'b1;
      t     = p[i] + 1;
    end
    if (!is_err) begin
      pll_q.push_back(p[4]);
      inc_q.push_back(t);
      last = p[4];
      for (int j = 1; j < SPF; j++) begin
        if (g[j] > S) begin
          is_err = 1'b1;
          code   = 6;
          end_e  = last + 1 + S;
          break;
        end
        c = last + g[j];
        pll_q.push_back(c);
        inc_q.push_back(c + 1);
        last = c;
        if (j == SPF - 1) end_e = c + 1;
      end
    end
    if (abort_at >= 1 && abort_at <= end_e) begin
      is_err = 1'b1;
      code   = 7;
      end_e  = abort_at;
      for (int i = inc_q.size() - 1; i >= 0; i--)
        if (inc_q[i] >= abort_at) inc_q.delete(i);
    end

    kmax = end_e + F + 3;
    for (int k = 0; k <= kmax; k++) begin
      frame_req      = (k == 0);
      abort          = (k == abort_at);
      ready_cut      = pv[0] && k >= p[0] && k <= end_e;
      ready_carry    = pv[1] && k >= p[1] && k <= end_e;
      ready_fil      = pv[2] && k >= p[2] && k <= end_e;
      ready_sampling = pv[3] && k >= p[3] && k <= end_e;
      drive_pll = 1'b0;
      foreach (pll_q[i]) if (pll_q[i] == k && k <= end_e) drive_pll = 1'b1;
      ready_pll = drive_pll;
      @(posedge clk);
      #1;
      symx = 0;
      foreach (inc_q[i]) if (inc_q[i] <= k) symx++;
      tg = $sformatf("f%0d k%0d", id, k);
      check({tg, " busy"}, 32'(busy), 32'(k < end_e));
      check({tg, " start"}, 32'(start), 32'(k >= F && k < end_e));
      check({tg, " chain_rst_n"}, 32'(chain_rst_n),
            32'(!((k < F && k < end_e) || (is_err && k >= end_e && k < end_e + F))));
      check({tg, " done"}, 32'(done), 32'(!is_err && k == end_e));
      check({tg, " err"}, 32'(err), 32'(is_err && k >= end_e));
      check({tg, " err_code"}, 32'(err_code), (is_err && k >= end_e) ? 32'(code) : 32'd0);
      check({tg, " sym_cnt"}, 32'(sym_cnt), 32'(symx));
      if (stop_sym > 0 && symx == stop_sym) break;
    end
    clear_inputs();
    if (stop_sym <= 0) begin
      if (is_err) err_model++;
      else ok_model++;
      check_stats($sformatf("f%0d", id));
      $display("frame %0d: %s code=%0d sym=%0d end_edge=%0d", id,
               is_err ? "error" : "done", code, inc_q.size(), end_e);
    end else begin
      $display("frame %0d: stopped at sym=%0d for reset", id, stop_sym);
    end
  endtask

  task automatic set_frame(input int dv, input int gv, input int a);
    for (int i = 0; i < 5; i++) d[i] = dv;
    for (int j = 0; j < 4; j++) g[j] = gv;
    abort_at = a;
  endtask

  initial begin
    #2;
    check("reset chain_rst_n", 32'(chain_rst_n), 32'd0);
    check("reset start", 32'(start), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sym_cnt", 32'(sym_cnt), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle chain_rst_n", 32'(chain_rst_n), 32'd1);
    check("idle busy", 32'(busy), 32'd0);

    set_frame(19, 20, -1);
    run_frame(1, 0);

    set_frame(19, 20, -1);
    d[2] = T;
    run_frame(2, 0);

    set_frame(19, 20, -1);
    g[2] = S + 1;
    run_frame(3, 0);

    set_frame(19, 20, -1);
    abort_at = (F + 1) + d[0] + 1 + d[1] + 1;
    run_frame(4, 0);

    set_frame(19, 20, -1);
    run_frame(5, 0);

    set_frame(T - 1, S, -1);
    run_frame(6, 0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 5; i++) begin
        case ($urandom_range(0, 11))
          0:       d[i] = T;
          1:       d[i] = T - 1;
          2:       d[i] = 0;
          default: d[i] = $urandom_range(0, T - 1);
        endcase
      end
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 11))
          0:       g[j] = S + 1;
          1:       g[j] = S;
          default: g[j] = $urandom_range(2, S);
        endcase
      end
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 160)) : -1;
      run_frame(10 + n, 0);
    end

    set_frame(15, 10, -1);
    run_frame(40, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrun chain_rst_n", 32'(chain_rst_n), 32'd0);
    check("midrun start", 32'(start), 32'd0);
    check("midrun busy", 32'(busy), 32'd0);
    check("midrun sym_cnt", 32'(sym_cnt), 32'd0);
    check("midrun done", 32'(done), 32'd0);
    check("midrun err", 32'(err), 32'd0);
    check("midrun err_code", 32'(err_code), 32'd0);
    ok_model  = 0;
    err_model = 0;
    check_stats("midrun");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset start", 32'(start), 32'd0);
    check("post-reset chain_rst_n", 32'(chain_rst_n), 32'd1);
    check("post-reset sym_cnt", 32'(sym_cnt), 32'd0);
    check("post-reset err", 32'(err), 32'd0);
    $display("frame 41: reset mid-run, block idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
